// File: rtl/fetch_stage.sv
// fetch_stage: program counter, fetch FSM with one-entry hold buffer,
// redirect squash handling and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        IF_Flush,
  input  logic        Branch,
  input  logic [31:0] Branch_Target,
  input  logic [1:0]  Jump,
  input  logic [31:0] Jump_Target,
  input  logic [31:0] JR_Target,
  input  logic        IMEM_Ack,
  input  logic [31:0] IMEM_Data,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  output logic [31:0] IF_PC_4,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PC_4,
  output logic        ID_Valid,
  output logic        Fetch_Busy
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] r_hold;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc4;
  logic        r_id_valid;

  logic        w_jr;
  logic        w_j;
  logic        w_br;
  logic        w_redir;
  logic [31:0] w_redir_pc;
  logic [31:0] w_sq_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_word;
  logic        w_word_vld;
  logic        w_adv;

  assign w_pc4   = r_pc + 32'd4;
  assign w_jr    = (Jump == 2'b10);
  assign w_j     = (Jump == 2'b01);
  assign w_br    = Branch & ~w_jr & ~w_j;
  assign w_redir = w_jr | w_j | Branch;

  // Redirect target; the selects are already priority-qualified
  always_comb begin
    w_redir_pc = w_pc4;
    unique case (1'b1)
      w_jr:    w_redir_pc = JR_Target & ALIGN;
      w_j:     w_redir_pc = Jump_Target & ALIGN;
      w_br:    w_redir_pc = Branch_Target & ALIGN;
      default: w_redir_pc = w_pc4;
    endcase
  end

  // A newer redirect while squashing replaces the latched one
  assign w_sq_pc = w_redir ? w_redir_pc : r_tgt;

  assign w_word_vld = ~w_redir &
                      (((r_state == FETCH) & IMEM_Ack) |
                       (r_state == HOLD));
  assign w_word = (r_state == HOLD) ? r_hold : IMEM_Data;
  assign w_adv  = w_word_vld & IFIDWrite & ~IF_Flush & PCWrite;

  assign IMEM_Req   = RESET & (r_state != HOLD);
  assign IMEM_Addr  = r_pc;
  assign IF_PC_4    = w_pc4;
  assign Fetch_Busy = RESET &
                      ((r_state != FETCH) | ~IMEM_Ack);

  assign ID_Instruction = r_id_instr;
  assign ID_PC_4        = r_id_pc4;
  assign ID_Valid       = r_id_valid;

  // PC, fetch state, hold buffer and latched redirect target
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC & ALIGN;
      r_tgt   <= 32'd0;
      r_hold  <= 32'd0;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (w_redir) begin
            if (IMEM_Ack) begin
              r_pc <= w_redir_pc;
            end else begin
              r_tgt   <= w_redir_pc;
              r_state <= SQUASH;
            end
          end else if (IMEM_Ack) begin
            if (IFIDWrite) begin
              if (w_adv) r_pc <= w_pc4;
            end else begin
              r_hold  <= IMEM_Data;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (w_redir) begin
            r_pc    <= w_redir_pc;
            r_state <= FETCH;
          end else if (IFIDWrite) begin
            if (w_adv) r_pc <= w_pc4;
            r_state <= FETCH;
          end
        end
        SQUASH: begin
          if (IMEM_Ack) begin
            r_pc    <= w_sq_pc;
            r_state <= FETCH;
          end else begin
            r_tgt <= w_sq_pc;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // IF/ID register: flush beats write, no word means bubble
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_id_instr <= NOP_INSTR;
      r_id_pc4   <= 32'd0;
      r_id_valid <= 1'b0;
    end else if (IF_Flush) begin
      r_id_instr <= NOP_INSTR;
      r_id_pc4   <= 32'd0;
      r_id_valid <= 1'b0;
    end else if (IFIDWrite) begin
      if (w_word_vld) begin
        r_id_instr <= w_word;
        r_id_pc4   <= w_pc4;
        r_id_valid <= 1'b1;
      end else begin
        r_id_instr <= NOP_INSTR;
        r_id_pc4   <= 32'd0;
        r_id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios then random traffic
// against a queue-based fetch model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        PCWrite = 1'b0;
  logic        IFIDWrite = 1'b0;
  logic        IF_Flush = 1'b0;
  logic        Branch = 1'b0;
  logic [31:0] Branch_Target = 32'd0;
  logic [1:0]  Jump = 2'b00;
  logic [31:0] Jump_Target = 32'd0;
  logic [31:0] JR_Target = 32'd0;
  logic        IMEM_Ack = 1'b0;
  logic [31:0] IMEM_Data = 32'd0;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic [31:0] IF_PC_4;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PC_4;
  logic        ID_Valid;
  logic        Fetch_Busy;

  int n_chk = 0;
  int n_fail = 0;

  fetch_stage #(
    .RESET_PC (RPC),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PCWrite       (PCWrite),
    .IFIDWrite     (IFIDWrite),
    .IF_Flush      (IF_Flush),
    .Branch        (Branch),
    .Branch_Target (Branch_Target),
    .Jump          (Jump),
    .Jump_Target   (Jump_Target),
    .JR_Target     (JR_Target),
    .IMEM_Ack      (IMEM_Ack),
    .IMEM_Data     (IMEM_Data),
    .IMEM_Req      (IMEM_Req),
    .IMEM_Addr     (IMEM_Addr),
    .IF_PC_4       (IF_PC_4),
    .ID_Instruction(ID_Instruction),
    .ID_PC_4       (ID_PC_4),
    .ID_Valid      (ID_Valid),
    .Fetch_Busy    (Fetch_Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(input logic pcw, input logic ifw,
                     input logic fl, input logic br,
                     input logic [31:0] bt,
                     input logic [1:0] jp,
                     input logic [31:0] jt,
                     input logic [31:0] jrt,
                     input logic ack,
                     input logic [31:0] d);
    PCWrite       = pcw;
    IFIDWrite     = ifw;
    IF_Flush      = fl;
    Branch        = br;
    Branch_Target = bt;
    Jump          = jp;
    Jump_Target   = jt;
    JR_Target     = jrt;
    IMEM_Ack      = ack;
    IMEM_Data     = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // reference model state
  logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
  logic        m_valid, m_pc4_dc, m_sq, m_req;
  logic [31:0] q_hold[$];
  logic        s_pcw, s_ifw, s_fl, s_br, s_ack, s_rd;
  logic [1:0]  s_jp;
  logic [31:0] s_bt, s_jt, s_jrt, s_d, s_rpc, s_w, s_t;
  logic        s_have, s_busy;
  int          r, k;

  initial begin
    drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rst_req", IMEM_Req, 0);
    chk("rst_valid", ID_Valid, 0);
    chk("rst_instr", ID_Instruction, NOP);
    chk("rst_idpc4", ID_PC_4, 0);
    chk("rst_addr", IMEM_Addr, RPC);
    @(negedge CLK);
    RESET = 1'b1;
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    chk("first_req", IMEM_Req, 1);
    chk("first_addr", IMEM_Addr, RPC);
    chk("first_pc4", IF_PC_4, RPC + 32'd4);
    chk("first_busy", Fetch_Busy, 1);

    // zero-wait stream
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 32'hAAAA_0001);
    #1 chk("zw_busy", Fetch_Busy, 0);
    tick();
    chk("zw_a", ID_Instruction, 32'hAAAA_0001);
    chk("zw_a_pc4", ID_PC_4, 4);
    chk("zw_a_v", ID_Valid, 1);
    chk("zw_addr4", IMEM_Addr, 4);
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 32'hBBBB_0002);
    tick();
    chk("zw_b", ID_Instruction, 32'hBBBB_0002);
    chk("zw_b_pc4", ID_PC_4, 8);
    chk("zw_addr8", IMEM_Addr, 8);
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 32'hCCCC_0003);
    tick();
    chk("zw_c", ID_Instruction, 32'hCCCC_0003);
    chk("zw_c_pc4", ID_PC_4, 12);
    chk("zw_addr12", IMEM_Addr, 12);

    // stall: word parked in hold buffer
    drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 32'hDDDD_0004);
    tick();
    chk("st_keep", ID_Instruction, 32'hCCCC_0003);
    chk("st_keep_pc4", ID_PC_4, 12);
    chk("st_req", IMEM_Req, 0);
    chk("st_addr", IMEM_Addr, 12);
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1 chk("st_busy", Fetch_Busy, 1);
    tick();
    chk("st_rel", ID_Instruction, 32'hDDDD_0004);
    chk("st_rel_pc4", ID_PC_4, 16);
    chk("st_addr16", IMEM_Addr, 16);
    chk("st_req1", IMEM_Req, 1);

    // branch + flush with slow memory
    drv(1, 0, 1, 1, 32'h40, 2'b00, 0, 0, 0, 0);
    tick();
    chk("br_valid", ID_Valid, 0);
    chk("br_instr", ID_Instruction, NOP);
    chk("br_idpc4", ID_PC_4, 0);
    chk("br_req", IMEM_Req, 1);
    chk("br_addr", IMEM_Addr, 32'h10);
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1 chk("br_busy", Fetch_Busy, 1);
    tick();
    chk("br_addr2", IMEM_Addr, 32'h10);
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 32'hEEEE_0005);
    tick();
    chk("br_tgt", IMEM_Addr, 32'h40);
    chk("br_drop", ID_Instruction, NOP);
    chk("br_drop_v", ID_Valid, 0);

    // redirect priority and target alignment
    drv(1, 1, 0, 1, 32'h200, 2'b10, 32'h300, 32'h100,
        1, 32'hF0F0_0006);
    tick();
    chk("pri_jr", IMEM_Addr, 32'h100);
    chk("pri_jr_v", ID_Valid, 0);
    drv(1, 1, 0, 1, 32'h200, 2'b01, 32'h300, 32'h100,
        1, 32'hF0F0_0007);
    tick();
    chk("pri_j", IMEM_Addr, 32'h300);
    drv(1, 1, 0, 1, 32'h203, 2'b11, 32'h300, 32'h100,
        1, 32'hF0F0_0008);
    tick();
    chk("pri_br11", IMEM_Addr, 32'h200);

    // wrap at top of address space
    drv(1, 1, 0, 0, 0, 2'b01, 32'hFFFF_FFFC, 0, 1, 0);
    tick();
    chk("wr_addr", IMEM_Addr, 32'hFFFF_FFFC);
    chk("wr_pc4", IF_PC_4, 0);
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 32'h6666_0009);
    tick();
    chk("wr_next", IMEM_Addr, 0);
    chk("wr_instr", ID_Instruction, 32'h6666_0009);
    chk("wr_idpc4", ID_PC_4, 0);
    chk("wr_v", ID_Valid, 1);

    // async reset in the middle of a squash
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 32'h7777_000A);
    tick();
    chk("ar_addr4", IMEM_Addr, 4);
    drv(0, 0, 0, 1, 32'h80, 2'b00, 0, 0, 0, 0);
    tick();
    chk("ar_sq_v", ID_Valid, 1);
    chk("ar_sq_addr", IMEM_Addr, 4);
    drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2 RESET = 1'b0;
    #1;
    chk("ar_req", IMEM_Req, 0);
    chk("ar_valid", ID_Valid, 0);
    chk("ar_instr", ID_Instruction, NOP);
    chk("ar_addr", IMEM_Addr, RPC);
    @(negedge CLK);
    RESET = 1'b1;
    drv(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    chk("ar_rel_req", IMEM_Req, 1);
    chk("ar_rel_pc4", IF_PC_4, RPC + 32'd4);

    // random traffic against the model
    m_pc = RPC; m_tgt = 0; m_sq = 0;
    m_instr = NOP; m_pc4 = 0; m_valid = 0; m_pc4_dc = 0;
    q_hold.delete();
    for (int c = 0; c < 3000; c++) begin
      chk("m_instr", ID_Instruction, m_instr);
      chk("m_valid", ID_Valid, m_valid);
      if (!m_pc4_dc) chk("m_idpc4", ID_PC_4, m_pc4);
      m_req = (q_hold.size() == 0);
      chk("m_addr", IMEM_Addr, m_pc);
      chk("m_pc4", IF_PC_4, m_pc + 32'd4);
      chk("m_req", IMEM_Req, m_req);

      r = $urandom_range(0, 9);
      s_pcw = 1; s_ifw = 1;
      if (r < 2) begin s_pcw = 0; s_ifw = 0; end
      else if (r == 2) s_pcw = 0;
      else if (r == 3) s_ifw = 0;
      s_rd = ($urandom_range(0, 7) == 0);
      s_jp = 2'b00; s_br = 0;
      if (s_rd) begin
        k = $urandom_range(0, 3);
        case (k)
          0: s_br = 1;
          1: begin s_jp = 2'b01; s_br = 1'($urandom_range(0, 1)); end
          2: begin s_jp = 2'b10; s_br = 1'($urandom_range(0, 1)); end
          default: begin s_jp = 2'b11; s_br = 1; end
        endcase
      end else if ($urandom_range(0, 5) == 0) begin
        s_jp = 2'b11;
      end
      s_fl = s_rd && ($urandom_range(0, 1) == 1);
      s_ack = m_req && ($urandom_range(0, 2) != 0);
      s_bt = $urandom; s_jt = $urandom; s_jrt = $urandom;
      s_d = $urandom;
      drv(s_pcw, s_ifw, s_fl, s_br, s_bt, s_jp, s_jt, s_jrt,
          s_ack, s_d);
      s_busy = !m_req || m_sq || !s_ack;
      #1 chk("m_busy", Fetch_Busy, s_busy);

      @(posedge CLK);
      s_rd = (s_jp == 2'b10) || (s_jp == 2'b01) || s_br;
      s_rpc = (s_jp == 2'b10) ? s_jrt :
              (s_jp == 2'b01) ? s_jt : s_bt;
      s_rpc = s_rpc & 32'hFFFF_FFFC;
      s_have = (q_hold.size() != 0) || (s_ack && !m_sq);
      s_w = (q_hold.size() != 0) ? q_hold[0] : s_d;
      if (s_fl) begin
        m_instr = NOP; m_pc4 = 0; m_valid = 0; m_pc4_dc = 0;
      end else if (s_ifw) begin
        if (!s_rd && s_have) begin
          m_instr = s_w; m_pc4 = m_pc + 32'd4;
          m_valid = 1; m_pc4_dc = 0;
        end else begin
          m_instr = NOP; m_valid = 0; m_pc4_dc = 1;
        end
      end
      if (m_sq) begin
        s_t = s_rd ? s_rpc : m_tgt;
        if (s_ack) begin m_pc = s_t; m_sq = 0; end
        else m_tgt = s_t;
      end else if (s_rd) begin
        if (q_hold.size() != 0 || s_ack) m_pc = s_rpc;
        else begin m_sq = 1; m_tgt = s_rpc; end
        q_hold.delete();
      end else if (s_have) begin
        if (s_ifw) begin
          q_hold.delete();
          if (s_pcw) m_pc = m_pc + 32'd4;
        end else if (q_hold.size() == 0) begin
          q_hold.push_back(s_d);
        end
      end
      @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
